// File: rtl/fifo_serializer_if.sv
// Slice stream from the FIFO serializer to its downstream consumer.
// Valid/ready handshake carrying one OUT_WIDTH slice per transfer.
interface fifo_serializer_if #(
    parameter int OUT_WIDTH = 8
);
    logic                 valid_o;
    logic                 ready_i;
    logic [OUT_WIDTH-1:0] data_o;

    modport master (
        output valid_o,
        output data_o,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  data_o,
        output ready_i
    );
endinterface

// File: rtl/fifo_serializer.sv
// Pops FIFO words and streams them out as OUT_WIDTH slices, bubble-free.
// Define FIFO_SER_MSB_FIRST_EN to send slices MSB-first (default LSB-first).
module fifo_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_pop_o,
    output logic                  busy_o,
    fifo_serializer_if.master     s
);
    localparam int NSLICES  = DATA_WIDTH / OUT_WIDTH;
    localparam int CntWidth = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NSLICES - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_sreg;
    logic [CntWidth-1:0]   r_cnt;

    logic                  w_busy;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_pop;
    logic [OUT_WIDTH-1:0]  w_slice;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_busy = (r_state == S_SHIFT);
    assign w_last = (r_cnt == LastCnt);
    assign w_xfer = w_busy && s.ready_i;

    // Pop when idle, or on the last slice so the next word follows with no bubble.
    assign w_pop = !rst && !flush_i && !fifo_empty_i &&
                   (!w_busy || (w_xfer && w_last));

`ifdef FIFO_SER_MSB_FIRST_EN
    assign w_slice   = r_sreg[DATA_WIDTH-1 -: OUT_WIDTH];
    assign w_shifted = r_sreg << OUT_WIDTH;
`else
    assign w_slice   = r_sreg[OUT_WIDTH-1:0];
    assign w_shifted = r_sreg >> OUT_WIDTH;
`endif

    assign fifo_pop_o = w_pop;
    assign busy_o     = w_busy;
    assign s.valid_o  = w_busy;
    assign s.data_o   = w_busy ? w_slice : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (w_pop) begin
            r_sreg  <= fifo_data_i;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
        end else if (w_xfer) begin
            if (w_last) begin
                r_state <= S_IDLE;
            end else begin
                r_cnt  <= r_cnt + CntWidth'(1);
                r_sreg <= w_shifted;
            end
        end
    end
endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench for fifo_serializer: vector table, directed corners,
// and randomized traffic against a word/slice-index reference model.
module tb_fifo_serializer;
    localparam int DW = 64;
    localparam int OW = 8;
    localparam int NS = DW / OW;

    typedef struct {
        bit          rdy;
        bit          fl;
        bit          ev;
        logic [7:0]  ed;
        bit          ep;
        bit          eb;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_pop_o;
    logic          busy_o;

    logic [63:0]   d1;
    logic          e1;
    logic          p1_o;
    logic          b1_o;

    fifo_serializer_if #(.OUT_WIDTH(OW)) sif ();
    fifo_serializer_if #(.OUT_WIDTH(64)) sif1 ();

    fifo_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_pop_o   (fifo_pop_o),
        .busy_o       (busy_o),
        .s            (sif.master)
    );

    fifo_serializer #(.DATA_WIDTH(64), .OUT_WIDTH(64)) u_one (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .fifo_data_i  (d1),
        .fifo_empty_i (e1),
        .fifo_pop_o   (p1_o),
        .busy_o       (b1_o),
        .s            (sif1.master)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] q[$];
    logic [63:0]   q1[$];
    bit            m_have = 0;
    logic [DW-1:0] m_word = '0;
    int            m_idx = 0;
    bit            p_seen;
    bit            p1_seen;

    localparam logic [63:0] W1 = 64'h0807060504030201;
    localparam logic [63:0] W2 = 64'h1817161514131211;

    function automatic logic [OW-1:0] slice(logic [DW-1:0] w, int i);
`ifdef FIFO_SER_MSB_FIRST_EN
        return w[DW-1-i*OW -: OW];
`else
        return w[i*OW +: OW];
`endif
    endfunction

    // Byte k (1..8) of W1 in transmit order.
    function automatic logic [7:0] eb(int k);
`ifdef FIFO_SER_MSB_FIRST_EN
        return 8'(9 - k);
`else
        return 8'(k);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty_i = (q.size() == 0);
        fifo_data_i  = (q.size() != 0) ? q[0] : '0;
        e1           = (q1.size() == 0);
        d1           = (q1.size() != 0) ? q1[0] : '0;
    endtask

    task automatic sample(input bit mchk);
        bit ep;
        @(negedge clk);
        if (mchk) begin
            ep = !rst && !flush_i && (q.size() != 0) &&
                 (!m_have || (sif.ready_i && m_idx == NS - 1));
            chk("valid", 64'(sif.valid_o), 64'(m_have));
            chk("data", 64'(sif.data_o), m_have ? 64'(slice(m_word, m_idx)) : 64'd0);
            chk("pop", 64'(fifo_pop_o), 64'(ep));
            chk("busy", 64'(busy_o), 64'(m_have));
        end
        p_seen  = fifo_pop_o;
        p1_seen = p1_o;
    endtask

    task automatic adv();
        if (rst || flush_i) begin
            m_have = 0;
            m_idx  = 0;
        end else if (m_have && sif.ready_i) begin
            if (m_idx == NS - 1) begin
                if (q.size() != 0) begin
                    m_word = q[0];
                    m_idx  = 0;
                end else begin
                    m_have = 0;
                end
            end else begin
                m_idx++;
            end
        end else if (!m_have && q.size() != 0) begin
            m_have = 1;
            m_word = q[0];
            m_idx  = 0;
        end
        @(posedge clk);
        #1;
        if (p_seen && q.size() != 0) void'(q.pop_front());
        if (p1_seen && q1.size() != 0) void'(q1.pop_front());
        refresh();
    endtask

    task automatic tick(input bit mchk);
        sample(mchk);
        adv();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[14];
        int   run;
        int   maxrun;
        int   pops;
        bit   pop2ok;

        tv[0]  = '{1, 0, 0, 8'h00, 1, 0};
        tv[1]  = '{1, 0, 1, eb(1), 0, 1};
        tv[2]  = '{1, 0, 1, eb(2), 0, 1};
        tv[3]  = '{0, 0, 1, eb(3), 0, 1};
        tv[4]  = '{0, 0, 1, eb(3), 0, 1};
        tv[5]  = '{0, 0, 1, eb(3), 0, 1};
        tv[6]  = '{1, 0, 1, eb(3), 0, 1};
        tv[7]  = '{1, 0, 1, eb(4), 0, 1};
        tv[8]  = '{1, 0, 1, eb(5), 0, 1};
        tv[9]  = '{1, 0, 1, eb(6), 0, 1};
        tv[10] = '{1, 0, 1, eb(7), 0, 1};
        tv[11] = '{1, 0, 1, eb(8), 0, 1};
        tv[12] = '{1, 0, 0, 8'h00, 0, 0};
        tv[13] = '{1, 0, 0, 8'h00, 0, 0};

        rst          = 1;
        flush_i      = 0;
        sif.ready_i  = 1;
        sif1.ready_i = 1;
        refresh();
        tick(0);
        tick(1);
        rst = 0;
        sample(1);
        chk("rst_valid", 64'(sif.valid_o), 64'd0);
        chk("rst_data", 64'(sif.data_o), 64'd0);
        chk("rst_pop", 64'(fifo_pop_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        adv();

        // Single word with a 3-cycle stall on slice 2.
        q.push_back(W1);
        refresh();
        for (int i = 0; i < 14; i++) begin
            sif.ready_i = tv[i].rdy;
            flush_i     = tv[i].fl;
            sample(1);
            chk($sformatf("tv%0d_valid", i), 64'(sif.valid_o), 64'(tv[i].ev));
            chk($sformatf("tv%0d_data", i), 64'(sif.data_o), 64'(tv[i].ed));
            chk($sformatf("tv%0d_pop", i), 64'(fifo_pop_o), 64'(tv[i].ep));
            chk($sformatf("tv%0d_busy", i), 64'(busy_o), 64'(tv[i].eb));
            adv();
        end

        // Back-to-back words.
        sif.ready_i = 1;
        q.push_back(W1);
        q.push_back(W2);
        refresh();
        run    = 0;
        maxrun = 0;
        pops   = 0;
        pop2ok = 0;
        for (int c = 0; c < 20; c++) begin
            sample(1);
            if (sif.valid_o) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
            if (fifo_pop_o) begin
                pops++;
                if (pops == 2)
                    pop2ok = sif.valid_o && (sif.data_o == slice(W1, NS - 1));
            end
            adv();
        end
        chk("b2b_run", 64'(maxrun), 64'd16);
        chk("b2b_pops", 64'(pops), 64'd2);
        chk("b2b_pop2_on_last", 64'(pop2ok), 64'd1);

        // Flush after slice 3 is accepted.
        q.push_back(W1);
        refresh();
        for (int c = 0; c < 5; c++) tick(1);
        q.push_back(W2);
        refresh();
        flush_i = 1;
        sample(1);
        chk("flush_pop", 64'(fifo_pop_o), 64'd0);
        adv();
        flush_i = 0;
        sample(1);
        chk("flush_valid", 64'(sif.valid_o), 64'd0);
        chk("flush_busy", 64'(busy_o), 64'd0);
        adv();
        sample(1);
        chk("flush_restart", 64'(sif.data_o), 64'(slice(W2, 0)));
        adv();
        for (int c = 0; c < 12; c++) tick(1);

        // Reset while slice 5 is shown, FIFO empty afterwards.
        q.push_back(W1);
        refresh();
        for (int c = 0; c < 6; c++) tick(1);
        rst = 1;
        sample(1);
        chk("rst_mid_data", 64'(sif.data_o), 64'(slice(W1, 5)));
        adv();
        rst = 0;
        sample(1);
        chk("rstm_valid", 64'(sif.valid_o), 64'd0);
        chk("rstm_data", 64'(sif.data_o), 64'd0);
        chk("rstm_pop", 64'(fifo_pop_o), 64'd0);
        chk("rstm_busy", 64'(busy_o), 64'd0);
        adv();
        tick(1);

        // Single-slice configuration: one slice per pop.
        q1.push_back(W1);
        q1.push_back(W2);
        refresh();
        sample(1);
        chk("one_pop0", 64'(p1_o), 64'd1);
        chk("one_v0", 64'(sif1.valid_o), 64'd0);
        adv();
        sample(1);
        chk("one_d1", sif1.data_o, W1);
        chk("one_pop1", 64'(p1_o), 64'd1);
        adv();
        sample(1);
        chk("one_d2", sif1.data_o, W2);
        chk("one_pop2", 64'(p1_o), 64'd0);
        adv();
        sample(1);
        chk("one_v3", 64'(sif1.valid_o), 64'd0);
        chk("one_b3", 64'(b1_o), 64'd0);
        adv();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (q.size() < 4 && $urandom_range(0, 2) == 0)
                q.push_back({$urandom, $urandom});
            refresh();
            sif.ready_i = ($urandom_range(0, 9) < 7);
            flush_i     = ($urandom_range(0, 49) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
